// File: rtl/nms_stream_3x3.sv
// nms_stream_3x3: streaming 3x3 non-maximum suppression over a raster
// {score, flag} stream. Two internal line buffers feed a 3x3 window whose
// centre lags the input by IMG_W+1 pixels. At end of frame, IMG_W+1 bubbles
// flush the remaining centres.
// Optional feature macro: NMS_THRESH_EN adds an i_thresh port. When it is
// defined, a centre is kept only if its score is >= i_thresh.
module nms_stream_3x3 #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int SCORE_W = 8,
  parameter int BORDER  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_sof,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_flag,
`ifdef NMS_THRESH_EN
  input  logic [SCORE_W-1:0] i_thresh,
`endif
  output logic               o_valid,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_flag,
  output logic               o_eof
);

  typedef struct packed {
    logic               flag;
    logic [SCORE_W-1:0] score;
  } pix_t;

  localparam int XW = $clog2(IMG_W);
  localparam int FW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] xi_q, xi_d, cx_q, cx_d;
  logic [YW-1:0] yi_q, yi_d, cy_q, cy_d;
  logic [FW-1:0] fc_q, fc_d;

  pix_t lb0_q [IMG_W];   // row y-1 relative to the input pixel
  pix_t lb1_q [IMG_W];   // row y-2 relative to the input pixel
  pix_t win_q [3][3];
  pix_t win_d [3][3];
  pix_t nw    [3][3];    // window after this step; the centre is evaluated on it

  logic               o_valid_q, o_valid_d, o_flag_q, o_flag_d, o_eof_q, o_eof_d;
  logic [SCORE_W-1:0] o_score_q, o_score_d;

  logic          accept, restart, step, emit, keep, border, thr_ok;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  pix_t          new_pix;

  assign i_ready = (state_q != S_FLUSH);
  assign o_valid = o_valid_q;
  assign o_score = o_score_q;
  assign o_flag  = o_flag_q;
  assign o_eof   = o_eof_q;

  // Handshake, frame restart and per-step input position.
  always_comb begin
    accept  = i_valid && i_ready;
    restart = accept && i_sof;
    step    = (state_q == S_FLUSH) || (accept && ((state_q == S_RUN) || i_sof));
    x_in    = restart ? '0 : xi_q;
    y_in    = restart ? '0 : yi_q;
    new_pix = '0;
    if (state_q != S_FLUSH) new_pix = '{flag: i_flag, score: i_score};
    // A centre exists once IMG_W+1 pixels of the frame have been seen.
    emit = step && ((state_q == S_FLUSH) || (y_in > YW'(1)) ||
                    ((y_in == YW'(1)) && (x_in != '0)));
  end

  // Shift the window one column left and append the line-buffer column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win_q[r][1];
      nw[r][1] = win_q[r][2];
    end
    nw[0][2] = lb1_q[x_in];
    nw[1][2] = lb0_q[x_in];
    nw[2][2] = new_pix;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_d[r][c] = step ? nw[r][c] : win_q[r][c];
  end

  // Keep rule: earlier flagged neighbours need a strictly lower score, later
  // ones need a lower-or-equal score. Out-of-image neighbours are ignored,
  // which also hides stale buffer rows and the line wrap.
  always_comb begin
    logic nb_ok;
    nb_ok = 1'b0;
`ifdef NMS_THRESH_EN
    thr_ok = (nw[1][1].score >= i_thresh);
`else
    thr_ok = 1'b1;
`endif
    keep = nw[1][1].flag && thr_ok;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        nb_ok = !(((r == 0) && (cy_q == '0)) || ((r == 2) && (cy_q == YW'(IMG_H-1))) ||
                  ((c == 0) && (cx_q == '0)) || ((c == 2) && (cx_q == XW'(IMG_W-1))));
        if (!((r == 1) && (c == 1)) && nb_ok && nw[r][c].flag) begin
          if ((r == 0) || ((r == 1) && (c == 0))) begin
            if (nw[1][1].score <= nw[r][c].score) keep = 1'b0;
          end else begin
            if (nw[1][1].score < nw[r][c].score) keep = 1'b0;
          end
        end
      end
    end
    border = (int'(cx_q) < BORDER) || (int'(cx_q) >= IMG_W - BORDER) ||
             (int'(cy_q) < BORDER) || (int'(cy_q) >= IMG_H - BORDER);
  end

  // Counters, FSM and output register next-state.
  always_comb begin
    state_d = state_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fc_d    = fc_q;
    if (step) begin
      if (x_in == XW'(IMG_W-1)) begin
        xi_d = '0;
        yi_d = y_in + YW'(1);
      end else begin
        xi_d = x_in + XW'(1);
        yi_d = y_in;
      end
    end
    if (restart) begin
      cx_d = '0;
      cy_d = '0;
    end else if (emit) begin
      if (cx_q == XW'(IMG_W-1)) begin
        cx_d = '0;
        cy_d = (cy_q == YW'(IMG_H-1)) ? '0 : cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end
    case (state_q)
      S_IDLE: if (restart) state_d = S_RUN;
      S_RUN: begin
        if (accept && (x_in == XW'(IMG_W-1)) && (y_in == YW'(IMG_H-1))) begin
          state_d = S_FLUSH;
          fc_d    = '0;
        end
      end
      S_FLUSH: begin
        fc_d = fc_q + FW'(1);
        if (fc_q == FW'(IMG_W)) begin
          state_d = S_IDLE;
          fc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    o_valid_d = emit;
    o_flag_d  = emit && keep && !border;
    o_score_d = o_flag_d ? nw[1][1].score : '0;
    o_eof_d   = emit && (cx_q == XW'(IMG_W-1)) && (cy_q == YW'(IMG_H-1));
  end

  // Control state, window and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      xi_q      <= '0;
      yi_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fc_q      <= '0;
      o_valid_q <= 1'b0;
      o_flag_q  <= 1'b0;
      o_eof_q   <= 1'b0;
      o_score_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      state_q   <= state_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fc_q      <= fc_d;
      o_valid_q <= o_valid_d;
      o_flag_q  <= o_flag_d;
      o_eof_q   <= o_eof_d;
      o_score_q <= o_score_d;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= win_d[r][c];
    end
  end

  // Line buffers: the column read this step moves up one row.
  always_ff @(posedge i_clk) begin
    if (step) begin
      lb1_q[x_in] <= lb0_q[x_in];
      lb0_q[x_in] <= new_pix;
    end
  end

endmodule

// File: tb/tb_nms_stream_3x3.sv
// Directed bench for nms_stream_3x3 on an 8x6 image. Two instances share the
// stimulus: dut0 has BORDER=0 and dut1 has BORDER=1.
module tb_nms_stream_3x3;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0, i_sof = 1'b0, i_flag = 1'b0;
  logic [7:0] i_score = 8'd0;
  logic       rdy0, rdy1, ov0, ov1, of0, of1, oe0, oe1;
  logic [7:0] os0, os1;
`ifdef NMS_THRESH_EN
  logic [7:0] thresh = 8'd0;
`endif

  always #5 clk = ~clk;

  nms_stream_3x3 #(.IMG_W(W), .IMG_H(H), .SCORE_W(8), .BORDER(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy0), .i_sof(i_sof),
    .i_score(i_score), .i_flag(i_flag),
`ifdef NMS_THRESH_EN
    .i_thresh(thresh),
`endif
    .o_valid(ov0), .o_score(os0), .o_flag(of0), .o_eof(oe0));

  nms_stream_3x3 #(.IMG_W(W), .IMG_H(H), .SCORE_W(8), .BORDER(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy1), .i_sof(i_sof),
    .i_score(i_score), .i_flag(i_flag),
`ifdef NMS_THRESH_EN
    .i_thresh(thresh),
`endif
    .o_valid(ov1), .o_score(os1), .o_flag(of1), .o_eof(oe1));

  int checks = 0;
  int failures = 0;

  logic [7:0] img_s [N];
  logic       img_f [N];
  logic [7:0] e0_s [N];
  logic [7:0] e1_s [N];
  logic [7:0] r0_s [64];
  logic [7:0] r1_s [64];
  logic       r0_f [64];
  logic       r1_f [64];
  int ocnt = 0, ocnt1 = 0, eof_cnt = 0, eof_idx = -1;

  // Output recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (oe0) begin
      eof_cnt++;
      eof_idx = ocnt;
    end
    if (ov0) begin
      if (ocnt < 64) begin r0_s[ocnt] = os0; r0_f[ocnt] = of0; end
      ocnt++;
    end
    if (ov1) begin
      if (ocnt1 < 64) begin r1_s[ocnt1] = os1; r1_f[ocnt1] = of1; end
      ocnt1++;
    end
  end

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      img_s[i] = 8'd0; img_f[i] = 1'b0; e0_s[i] = 8'd0; e1_s[i] = 8'd0;
    end
  endtask

  task automatic px(input int x, input int y, input int s);
    img_s[y*W+x] = 8'(s);
    img_f[y*W+x] = 1'b1;
  endtask

  task automatic ex(input int which, input int x, input int y, input int s);
    if (which == 0) e0_s[y*W+x] = 8'(s);
    else            e1_s[y*W+x] = 8'(s);
  endtask

  // Number of recorded outputs that differ from the expected picture.
  function automatic int diff_cnt(input int which);
    int d = 0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] es, as;
      logic       af;
      es = (which == 0) ? e0_s[i] : e1_s[i];
      as = (which == 0) ? r0_s[i] : r1_s[i];
      af = (which == 0) ? r0_f[i] : r1_f[i];
      if ((as !== es) || (af !== (es != 8'd0))) d++;
    end
    return d;
  endfunction

  // Drive one full frame, then count cycles with i_ready low until ready returns.
  task automatic send_frame(output int low);
    ocnt = 0; ocnt1 = 0; eof_cnt = 0; eof_idx = -1;
    for (int i = 0; i < 64; i++) begin
      r0_s[i] = 8'hxx; r1_s[i] = 8'hxx; r0_f[i] = 1'bx; r1_f[i] = 1'bx;
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_sof = (i == 0); i_score = img_s[i]; i_flag = img_f[i];
    end
    @(negedge clk);
    i_valid = 1'b0; i_sof = 1'b0; i_flag = 1'b0; i_score = 8'd0;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      if (!rdy0) low++;
      else if (low > 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ov0, of0, oe0, os0} !== 11'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {ov0, of0, oe0, os0});
    end
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      failures++; $display("FAIL reset_ready got=%b exp=11", {rdy0, rdy1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov1, of1, oe1, os1, rdy1} !== 12'd1) begin
      failures++; $display("FAIL after_reset_dut1 got=%h exp=1", {ov1, of1, oe1, os1, rdy1});
    end
  endtask

  task automatic test_single();
    int low;
    clear_all();
    px(3, 2, 50); ex(0, 3, 2, 50); ex(1, 3, 2, 50);
    send_frame(low);
    checks++;
    if (ocnt !== N) begin failures++; $display("FAIL single_count got=%0d exp=%0d", ocnt, N); end
    checks++;
    if (ocnt1 !== N) begin failures++; $display("FAIL single_count_b1 got=%0d exp=%0d", ocnt1, N); end
    checks++;
    if (diff_cnt(0) !== 0) begin failures++; $display("FAIL single_pixels got=%0d bad exp=0", diff_cnt(0)); end
    checks++;
    if (diff_cnt(1) !== 0) begin failures++; $display("FAIL single_pixels_b1 got=%0d bad exp=0", diff_cnt(1)); end
    checks++;
    if ((eof_cnt !== 1) || (eof_idx !== N - 1)) begin
      failures++; $display("FAIL single_eof got=%0d@%0d exp=1@%0d", eof_cnt, eof_idx, N - 1);
    end
  endtask

  task automatic test_tie();
    int low;
    clear_all();
    px(3, 2, 40); px(4, 2, 40);
    ex(0, 3, 2, 40); ex(1, 3, 2, 40);
    send_frame(low);
    checks++;
    if ((ocnt !== N) || (diff_cnt(0) !== 0)) begin
      failures++; $display("FAIL tie_plateau got=%0d bad cnt=%0d exp=0", diff_cnt(0), ocnt);
    end
    checks++;
    if (diff_cnt(1) !== 0) begin failures++; $display("FAIL tie_plateau_b1 got=%0d bad exp=0", diff_cnt(1)); end
    clear_all();
    px(3, 2, 40); px(4, 2, 40); px(4, 3, 41);
    ex(0, 4, 3, 41); ex(1, 4, 3, 41);
    send_frame(low);
    checks++;
    if ((ocnt !== N) || (diff_cnt(0) !== 0)) begin
      failures++; $display("FAIL tie_higher got=%0d bad cnt=%0d exp=0", diff_cnt(0), ocnt);
    end
    checks++;
    if (diff_cnt(1) !== 0) begin failures++; $display("FAIL tie_higher_b1 got=%0d bad exp=0", diff_cnt(1)); end
  endtask

  task automatic test_edges();
    int low;
    clear_all();
    px(0, 0, 9); px(7, 0, 9); px(0, 1, 5);
    ex(0, 0, 0, 9); ex(0, 7, 0, 9);
    send_frame(low);
    checks++;
    if ((ocnt !== N) || (diff_cnt(0) !== 0)) begin
      failures++; $display("FAIL edges_wrap got=%0d bad cnt=%0d exp=0", diff_cnt(0), ocnt);
    end
    checks++;
    if ((ocnt1 !== N) || (diff_cnt(1) !== 0)) begin
      failures++; $display("FAIL edges_border1 got=%0d bad cnt=%0d exp=0", diff_cnt(1), ocnt1);
    end
  endtask

  task automatic test_flush();
    int low;
    clear_all();
    send_frame(low);
    checks++;
    if (low !== W + 1) begin failures++; $display("FAIL flush_ready_low got=%0d exp=%0d", low, W + 1); end
    ocnt = 0;
    @(negedge clk);
    i_valid = 1'b1; i_sof = 1'b0; i_flag = 1'b1; i_score = 8'd99;
    @(negedge clk);
    i_valid = 1'b0; i_flag = 1'b0; i_score = 8'd0;
    repeat (2 * W + 4) @(negedge clk);
    checks++;
    if (ocnt !== 0) begin failures++; $display("FAIL idle_drop got=%0d exp=0", ocnt); end
  endtask

  task automatic test_abort();
    int low;
    clear_all();
    ocnt = 0; ocnt1 = 0; eof_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_sof = (i == 0); i_score = 8'd255; i_flag = 1'b1;
    end
    @(negedge clk);
    i_valid = 1'b0; i_sof = 1'b0; i_flag = 1'b0; i_score = 8'd0;
    @(negedge clk);
    checks++;
    if (ocnt !== 11) begin failures++; $display("FAIL abort_partial_count got=%0d exp=11", ocnt); end
    checks++;
    if ((r0_f[0] !== 1'b1) || (r0_s[0] !== 8'd255)) begin
      failures++; $display("FAIL abort_first_kept got=%b/%0d exp=1/255", r0_f[0], r0_s[0]);
    end
    px(3, 2, 50); ex(0, 3, 2, 50); ex(1, 3, 2, 50);
    send_frame(low);
    checks++;
    if (ocnt !== N) begin failures++; $display("FAIL abort_new_count got=%0d exp=%0d", ocnt, N); end
    checks++;
    if ((diff_cnt(0) !== 0) || (diff_cnt(1) !== 0)) begin
      failures++; $display("FAIL abort_new_pixels got=%0d/%0d bad exp=0/0", diff_cnt(0), diff_cnt(1));
    end
    checks++;
    if ((eof_cnt !== 1) || (eof_idx !== N - 1)) begin
      failures++; $display("FAIL abort_eof got=%0d@%0d exp=1@%0d", eof_cnt, eof_idx, N - 1);
    end
  endtask

  task automatic test_async_reset();
    int low;
    clear_all();
    px(3, 2, 50);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_sof = (i == 0); i_score = img_s[i]; i_flag = img_f[i];
    end
    @(negedge clk);
    i_valid = 1'b0; i_sof = 1'b0; i_flag = 1'b0; i_score = 8'd0;
    #2;
    checks++;
    if ({rdy0, ov0} !== 2'b01) begin failures++; $display("FAIL pre_reset_flush got=%b exp=01", {rdy0, ov0}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, ov0} !== 2'b10) begin failures++; $display("FAIL async_reset got=%b exp=10", {rdy0, ov0}); end
    @(negedge clk);
    rst_n = 1'b1;
    ex(0, 3, 2, 50); ex(1, 3, 2, 50);
    send_frame(low);
    checks++;
    if ((ocnt !== N) || (diff_cnt(0) !== 0)) begin
      failures++; $display("FAIL recover_frame got=%0d bad cnt=%0d exp=0", diff_cnt(0), ocnt);
    end
  endtask

`ifdef NMS_THRESH_EN
  task automatic test_thresh();
    int low;
    clear_all();
    thresh = 8'd30;
    px(2, 2, 29); px(5, 3, 30);
    ex(0, 5, 3, 30); ex(1, 5, 3, 30);
    send_frame(low);
    checks++;
    if ((ocnt !== N) || (diff_cnt(0) !== 0)) begin
      failures++; $display("FAIL thresh got=%0d bad cnt=%0d exp=0", diff_cnt(0), ocnt);
    end
    thresh = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_edges();
    test_flush();
    test_abort();
    test_async_reset();
`ifdef NMS_THRESH_EN
    test_thresh();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
